// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the MIPS32 general-purpose register file.
// Holds the enable polarities, bus widths, register count and the dump FSM state encoding.
package wb_regfile_pkg;

   localparam logic RstEnable   = 1'b1;
   localparam logic WriteEnable = 1'b1;
   localparam logic ReadEnable  = 1'b1;

   localparam int unsigned RegBusW     = 32;
   localparam int unsigned RegAddrBusW = 5;
   localparam int unsigned RegNum      = 32;

   localparam logic [RegBusW-1:0]     ZeroWord   = '0;
   localparam logic [RegAddrBusW-1:0] NOPRegAddr = '0;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StDump = 2'd1,
      StDone = 2'd2
   } dump_state_e;

endpackage

// File: rtl/wb_regfile_dump_ctrl.sv
// Dump controller for the register file: walks an index over every register, one beat per
// accepted valid/ready handshake, then signals completion with a single-cycle done pulse.
//   clk, rst       : clock, synchronous active-high reset
//   dump_start_i   : single-cycle dump request, honoured only when idle
//   dump_ready_i   : consumer accepts the current beat
//   dump_valid_o   : beat valid (DUMP state)
//   dump_busy_o    : high in DUMP and DONE
//   dump_done_o    : one-cycle pulse after the last beat is accepted
//   dump_idx_o     : register index of the current beat (read address into the storage)
module wb_regfile_dump_ctrl
   import wb_regfile_pkg::*;
#(
   parameter int unsigned ADDR_W   = RegAddrBusW,
   parameter int unsigned NUM_REGS = RegNum
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dump_start_i,
   input  logic              dump_ready_i,
   output logic              dump_valid_o,
   output logic              dump_busy_o,
   output logic              dump_done_o,
   output logic [ADDR_W-1:0] dump_idx_o
);

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q <= StIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      dump_valid_o = 1'b0;
      dump_busy_o  = 1'b0;
      dump_done_o  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (dump_start_i) begin
               state_d = StDump;
               idx_d   = '0;
            end
         end
         StDump: begin
            dump_valid_o = 1'b1;
            dump_busy_o  = 1'b1;
            if (dump_ready_i) begin
               // Last beat found by compare so a non-power-of-two count still terminates.
               if (idx_q == LastIdx) begin
                  state_d = StDone;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StDone: begin
            dump_busy_o = 1'b1;
            dump_done_o = 1'b1;
            state_d     = StIdle;
            idx_d       = '0;
         end
         default: begin
            state_d = StIdle;
            idx_d   = '0;
         end
      endcase
   end

   assign dump_idx_o = idx_q;

endmodule

// File: rtl/wb_regfile.sv
// MIPS32 general-purpose register file, fed by the MEM/WB writeback triple.
// Two combinational read ports with same-cycle write-to-read bypass, plus a handshaked
// dump engine that streams every register out in index order.
//   clk, rst                 : clock, synchronous active-high reset
//   we_i, waddr_i, wdata_i   : writeback enable / destination / data
//   re1_i, raddr1_i, rdata1_o: read port 1
//   re2_i, raddr2_i, rdata2_o: read port 2
//   dump_start_i, dump_ready_i, dump_valid_o, dump_addr_o, dump_data_o,
//   dump_busy_o, dump_done_o : debug dump stream
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = RegBusW,
   parameter int unsigned ADDR_W   = RegAddrBusW,
   parameter int unsigned NUM_REGS = RegNum
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re1_i,
   input  logic [ADDR_W-1:0] raddr1_i,
   output logic [DATA_W-1:0] rdata1_o,
   input  logic              re2_i,
   input  logic [ADDR_W-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata2_o,
   input  logic              dump_start_i,
   output logic              dump_valid_o,
   input  logic              dump_ready_i,
   output logic [ADDR_W-1:0] dump_addr_o,
   output logic [DATA_W-1:0] dump_data_o,
   output logic              dump_busy_o,
   output logic              dump_done_o
);

   localparam logic [DATA_W-1:0] Zero = DATA_W'(ZeroWord);
   localparam logic [ADDR_W-1:0] Nop  = ADDR_W'(NOPRegAddr);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [ADDR_W-1:0] dump_idx;

   // Three lookups share the same rules: two decode ports and the dump index.
   logic [2:0][ADDR_W-1:0] rd_addr;
   logic [2:0]             rd_en;
   logic [2:0][DATA_W-1:0] rd_data;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= Zero;
         end
      end else if (we_i == WriteEnable && waddr_i != Nop) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rd_addr[0] = raddr1_i;
      rd_en[0]   = re1_i;
      rd_addr[1] = raddr2_i;
      rd_en[1]   = re2_i;
      rd_addr[2] = dump_idx;
      rd_en[2]   = ReadEnable;
   end

   always_comb begin
      for (int p = 0; p < 3; p++) begin
         rd_data[p] = Zero;
         if (rst == RstEnable || rd_en[p] != ReadEnable || rd_addr[p] == Nop) begin
            rd_data[p] = Zero;
         end else if (we_i == WriteEnable && waddr_i == rd_addr[p]) begin
            rd_data[p] = wdata_i;
         end else begin
            rd_data[p] = regs_q[rd_addr[p]];
         end
      end
   end

   wb_regfile_dump_ctrl #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_dump_ctrl (
      .clk          (clk),
      .rst          (rst),
      .dump_start_i (dump_start_i),
      .dump_ready_i (dump_ready_i),
      .dump_valid_o (dump_valid_o),
      .dump_busy_o  (dump_busy_o),
      .dump_done_o  (dump_done_o),
      .dump_idx_o   (dump_idx)
   );

   assign rdata1_o    = rd_data[0];
   assign rdata2_o    = rd_data[1];
   assign dump_addr_o = dump_idx;
   assign dump_data_o = rd_data[2];

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic        re1 = 1'b0;
   logic [4:0]  raddr1 = '0;
   logic [31:0] rdata1;
   logic        re2 = 1'b0;
   logic [4:0]  raddr2 = '0;
   logic [31:0] rdata2;
   logic        dump_start = 1'b0;
   logic        dump_valid;
   logic        dump_ready = 1'b0;
   logic [4:0]  dump_addr;
   logic [31:0] dump_data;
   logic        dump_busy;
   logic        dump_done;

   beat_t       exp_q [$];
   beat_t       beat;
   logic [31:0] model [32];
   int          checks = 0;
   int          failures = 0;
   int          done_cnt = 0;

   wb_regfile dut (
      .clk          (clk),
      .rst          (rst),
      .we_i         (we),
      .waddr_i      (waddr),
      .wdata_i      (wdata),
      .re1_i        (re1),
      .raddr1_i     (raddr1),
      .rdata1_o     (rdata1),
      .re2_i        (re2),
      .raddr2_i     (raddr2),
      .rdata2_o     (rdata2),
      .dump_start_i (dump_start),
      .dump_valid_o (dump_valid),
      .dump_ready_i (dump_ready),
      .dump_addr_o  (dump_addr),
      .dump_data_o  (dump_data),
      .dump_busy_o  (dump_busy),
      .dump_done_o  (dump_done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      we = 1'b1;
      waddr = a[4:0];
      wdata = d;
      tick();
      we = 1'b0;
      if (a != 0) model[a] = d;
   endtask

   // Both ports against the model, sweeping port 2 in the opposite direction.
   task automatic read_all(input string tag);
      re1 = 1'b1;
      re2 = 1'b1;
      for (int a = 0; a < 32; a++) begin
         raddr1 = a[4:0];
         raddr2 = 5'(31 - a);
         #1;
         check_val({tag, "_p1"}, rdata1, model[a]);
         check_val({tag, "_p2"}, rdata2, model[31 - a]);
      end
   endtask

   // Scoreboard consumer: every accepted beat must match the oldest queued expectation.
   always @(negedge clk) begin
      if (dump_done === 1'b1) done_cnt++;
      if (dump_valid === 1'b1 && dump_ready === 1'b1) begin
         check_val("dump_beat_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            beat = exp_q.pop_front();
            check_val("dump_addr", 32'(dump_addr), 32'(beat.addr));
            check_val("dump_data", dump_data, beat.data);
         end
      end
   end

   task automatic run_dump(input bit toggle, input int abort_at);
      int idx = 0;
      bit aborted = 1'b0;
      bit wrote3 = 1'b0;
      logic rdy;
      done_cnt = 0;
      dump_ready = 1'b0;
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      for (int cyc = 0; cyc < 400 && idx < 32 && !aborted; cyc++) begin
         rdy = toggle ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
         if (idx == abort_at) begin
            dump_ready = 1'b0;
            rst = 1'b1;
            re1 = 1'b1;
            raddr1 = 5'd5;
            #1;
            check_val("rst_read_zero", rdata1, 32'h0);
            tick();
            check_val("abort_valid", 32'(dump_valid), 32'd0);
            check_val("abort_busy", 32'(dump_busy), 32'd0);
            rst = 1'b0;
            aborted = 1'b1;
         end else begin
            check_val("dump_valid", 32'(dump_valid), 32'd1);
            check_val("dump_addr_hold", 32'(dump_addr), 32'(idx));
            dump_ready = rdy;
            // Ignored request while a dump is in flight.
            dump_start = (cyc == 1);
            if (toggle && idx == 3 && !rdy && !wrote3) begin
               we = 1'b1;
               waddr = 5'd3;
               wdata = 32'hA5A5_A5A5;
               #1;
               check_val("dump_bypass", dump_data, 32'hA5A5_A5A5);
               model[3] = 32'hA5A5_A5A5;
               wrote3 = 1'b1;
            end
            if (rdy) exp_q.push_back('{addr: idx[4:0], data: model[idx]});
            tick();
            we = 1'b0;
            dump_start = 1'b0;
            if (rdy) idx++;
         end
      end
      dump_ready = 1'b0;
      if (abort_at >= 0) begin
         check_val("abort_reached", 32'(aborted), 32'd1);
         tick();
         tick();
         check_val("abort_no_done", 32'(done_cnt), 32'd0);
         check_val("abort_idle_valid", 32'(dump_valid), 32'd0);
         for (int a = 0; a < 32; a++) model[a] = 32'h0;
         exp_q.delete();
      end else begin
         check_val("dump_beats", 32'(idx), 32'd32);
         check_val("done_pulse", 32'(dump_done), 32'd1);
         check_val("done_busy", 32'(dump_busy), 32'd1);
         check_val("done_valid", 32'(dump_valid), 32'd0);
         tick();
         check_val("done_clear", 32'(dump_done), 32'd0);
         check_val("idle_busy", 32'(dump_busy), 32'd0);
         check_val("done_count", 32'(done_cnt), 32'd1);
         check_val("queue_drained", 32'(exp_q.size()), 32'd0);
      end
   endtask

   initial begin
      for (int a = 0; a < 32; a++) model[a] = 32'h0;
      rst = 1'b1;
      tick();
      tick();
      check_val("rst_valid", 32'(dump_valid), 32'd0);
      check_val("rst_busy", 32'(dump_busy), 32'd0);
      check_val("rst_done", 32'(dump_done), 32'd0);
      rst = 1'b0;
      read_all("reset_read");

      // Same-cycle bypass, then registered value.
      re1 = 1'b1;
      raddr1 = 5'd5;
      we = 1'b1;
      waddr = 5'd5;
      wdata = 32'hDEAD_BEEF;
      #1;
      check_val("bypass_p1", rdata1, 32'hDEAD_BEEF);
      tick();
      we = 1'b0;
      model[5] = 32'hDEAD_BEEF;
      #1;
      check_val("after_write_p1", rdata1, 32'hDEAD_BEEF);

      // Writes to register 0 are dropped.
      re2 = 1'b1;
      raddr2 = 5'd0;
      we = 1'b1;
      waddr = 5'd0;
      wdata = 32'hFFFF_FFFF;
      #1;
      check_val("r0_write_cycle", rdata2, 32'h0);
      tick();
      we = 1'b0;
      #1;
      check_val("r0_after", rdata2, 32'h0);

      // Read enable gating.
      wr(5, 32'h1234_5678);
      re1 = 1'b0;
      raddr1 = 5'd5;
      #1;
      check_val("re1_low", rdata1, 32'h0);
      re1 = 1'b1;
      #1;
      check_val("re1_high", rdata1, 32'h1234_5678);

      // Both ports bypass together.
      raddr1 = 5'd7;
      raddr2 = 5'd7;
      we = 1'b1;
      waddr = 5'd7;
      wdata = 32'h0BAD_F00D;
      #1;
      check_val("dual_bypass_p1", rdata1, 32'h0BAD_F00D);
      check_val("dual_bypass_p2", rdata2, 32'h0BAD_F00D);
      tick();
      we = 1'b0;
      model[7] = 32'h0BAD_F00D;

      for (int n = 1; n < 32; n++) wr(n, 32'(n) * 32'h0101_0101);
      read_all("filled_read");

      run_dump(1'b0, -1);

      // Reset beats a simultaneous start request.
      rst = 1'b1;
      dump_start = 1'b1;
      tick();
      rst = 1'b0;
      dump_start = 1'b0;
      tick();
      check_val("rst_beats_start", 32'(dump_valid), 32'd0);
      for (int n = 1; n < 32; n++) wr(n, 32'(n) * 32'h0101_0101);

      run_dump(1'b1, 10);
      read_all("post_abort_read");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
